tpu_skew_feeder: RTL

- Input staging stage that sits directly upstream of the systolic MAC array inside the TPU top.
- Captures N consecutive global-buffer lines of matrix A (row r per line) and matrix B (row k per line).
- Replays them as diagonally skewed operand wavefronts: left-edge lanes carry A, top-edge lanes carry B.
- The array then computes the output-stationary C = A x B that is drained as 37-bit results.

---
 rtl/tpu_skew_feeder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tpu_skew_feeder.sv
// Operand staging for the systolic MAC array: captures N lines of A and B,
// then replays them as diagonally skewed left-edge (A) and top-edge (B) wavefronts.
module tpu_skew_feeder #(
    parameter int unsigned N  = 32,
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] gbuff_a,
    input  logic [N*DW-1:0] gbuff_b,
    input  logic            array_ready,
    output logic            feed_valid,
    output logic [N*DW-1:0] feed_a,
    output logic [N*DW-1:0] feed_b,
    output logic            feed_first,
    output logic            feed_last,
    output logic            done
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned LW = N * DW;
    localparam logic [CW-1:0] T_LAST = CW'(2 * N - 2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     t_q, t_d;
    logic              in_ready_q, in_ready_d;
    logic              feed_valid_q, feed_valid_d;
    logic [LW-1:0]     feed_a_q, feed_a_d;
    logic [LW-1:0]     feed_b_q, feed_b_d;
    logic              feed_first_q, feed_first_d;
    logic              feed_last_q, feed_last_d;
    logic              done_q, done_d;
    logic              wr_en;
    logic [AW-1:0]     wr_row;
    logic [CW:0]       diff;

    logic [DW-1:0]     a_buf_q [N][N];
    logic [DW-1:0]     a_buf_d [N][N];
    logic [DW-1:0]     b_buf_q [N][N];
    logic [DW-1:0]     b_buf_d [N][N];

    // Next-state, line count and beat counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        wr_en   = 1'b0;
        wr_row  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_row  = '0;
                    cnt_d   = AW'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == AW'(N - 1)) begin
                        cnt_d   = '0;
                        t_d     = '0;
                        state_d = S_FEED;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_FEED: begin
                if (array_ready) begin
                    if (t_q == T_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        t_d = t_q + CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Line capture: element j of the incoming line sits at the j-th lane from the MSB
    always_comb begin
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        if (wr_en) begin
            for (int unsigned j = 0; j < N; j++) begin
                a_buf_d[wr_row][j] = gbuff_a[DW*(N-j)-1 -: DW];
                b_buf_d[wr_row][j] = gbuff_b[DW*(N-j)-1 -: DW];
            end
        end
    end

    // Skewed lane selection for the beat that will be presented next cycle
    always_comb begin
        feed_a_d = '0;
        feed_b_d = '0;
        diff     = '0;
        if (state_d == S_FEED) begin
            for (int unsigned r = 0; r < N; r++) begin
                diff = {1'b0, t_d} - (CW+1)'(r);
                if (!diff[CW] && (diff[CW-1:0] < CW'(N))) begin
                    feed_a_d[DW*(N-r)-1 -: DW] = a_buf_q[r][diff[AW-1:0]];
                    feed_b_d[DW*(N-r)-1 -: DW] = b_buf_q[diff[AW-1:0]][r];
                end
            end
        end
    end

    always_comb begin
        in_ready_d   = (state_d == S_IDLE) || (state_d == S_LOAD);
        feed_valid_d = (state_d == S_FEED);
        feed_first_d = (state_d == S_FEED) && (t_d == '0);
        feed_last_d  = (state_d == S_FEED) && (t_d == T_LAST);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            t_q          <= '0;
            in_ready_q   <= 1'b1;
            feed_valid_q <= 1'b0;
            feed_a_q     <= '0;
            feed_b_q     <= '0;
            feed_first_q <= 1'b0;
            feed_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            t_q          <= t_d;
            in_ready_q   <= in_ready_d;
            feed_valid_q <= feed_valid_d;
            feed_a_q     <= feed_a_d;
            feed_b_q     <= feed_b_d;
            feed_first_q <= feed_first_d;
            feed_last_q  <= feed_last_d;
            done_q       <= done_d;
        end
    end

    // Operand buffers keep their contents across reset
    always_ff @(posedge clk) begin
        a_buf_q <= a_buf_d;
        b_buf_q <= b_buf_d;
    end

    assign in_ready   = in_ready_q;
    assign feed_valid = feed_valid_q;
    assign feed_a     = feed_a_q;
    assign feed_b     = feed_b_q;
    assign feed_first = feed_first_q;
    assign feed_last  = feed_last_q;
    assign done       = done_q;

endmodule
